// File: rtl/systolic_tile_scheduler.sv
// Purpose: sequence one matrix tile through a ROWS x COLS systolic array (buffer reads, skewed lanes, drain count).
// Latency: buffer word returns 1 cycle after its read strobe; row r / column c sees it r / c cycles later.
// Backpressure: one tile at a time; cmd_ready_o is high only in IDLE, and result beats are never stalled.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   cmd_valid_i/cmd_ready_o           tile command handshake carrying cmd_k_i (K) and cmd_base_i
//   act_rd_* / wgt_rd_*               activation / weight buffer read strobe, address, returned word
//   act_o, act_en_o, end_o            skewed west-edge activation lanes and end-of-reduction markers
//   wgt_o, wgt_en_o                   skewed north-edge weight lanes
//   clear_all_o, stop_weight_o        array clear pulse and weight-hold control
//   res_valid_i                       per-row result beats drained from the west edge
//   busy_o, done_o, err_o, err_code_o status: not idle, tile complete pulse, sticky error and its cause
module systolic_tile_scheduler #(
  parameter int DATA_WIDTH    = 16,
  parameter int ROWS          = 4,
  parameter int COLS          = 4,
  parameter int K_W           = 12,
  parameter int ADDR_W        = 12,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  input  logic [K_W-1:0]             cmd_k_i,
  input  logic [ADDR_W-1:0]          cmd_base_i,
  output logic                       act_rd_en_o,
  output logic [ADDR_W-1:0]          act_rd_addr_o,
  input  logic [ROWS*DATA_WIDTH-1:0] act_rd_data_i,
  output logic                       wgt_rd_en_o,
  output logic [ADDR_W-1:0]          wgt_rd_addr_o,
  input  logic [COLS*DATA_WIDTH-1:0] wgt_rd_data_i,
  output logic [ROWS*DATA_WIDTH-1:0] act_o,
  output logic [ROWS-1:0]            act_en_o,
  output logic [ROWS-1:0]            end_o,
  output logic [COLS*DATA_WIDTH-1:0] wgt_o,
  output logic [COLS-1:0]            wgt_en_o,
  output logic                       clear_all_o,
  output logic                       stop_weight_o,
  input  logic [ROWS-1:0]            res_valid_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_o,
  output logic [1:0]                 err_code_o
);

  // Longest skew across both edges; FLUSH lasts this long so every lane has emptied.
  localparam int LANES = (ROWS > COLS) ? ROWS : COLS;
  localparam int CNT_W = $clog2(COLS + 1);
  localparam int TMR_W = $clog2(DRAIN_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_STREAM = 3'd2,
    S_FLUSH  = 3'd3,
    S_DRAIN  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic [K_W-1:0]          k_q;
  logic [K_W-1:0]          idx_q;
  logic [ADDR_W-1:0]       base_q;
  logic [TMR_W-1:0]        tmr_q;
  logic [CNT_W-1:0]        cnt_q [ROWS];
  logic [ROWS-1:0]         cnt_full;
  logic                    rows_full;
  logic                    accept;
  logic                    rd_last;
  logic                    counting;
  logic                    ovf_beat;
  logic                    drain_tmo;
  logic                    rd_vld_q;
  logic                    rd_last_q;
  logic                    err_q;
  logic [1:0]              err_code_q;
  logic                    done_q;
  logic                    stop_weight_q;
  logic [ROWS*DATA_WIDTH-1:0] act_s0;
  logic [COLS*DATA_WIDTH-1:0] wgt_s0;

  assign accept    = cmd_valid_i && (state_q == S_IDLE);
  assign rd_last   = (state_q == S_STREAM) && (idx_q == k_q - K_W'(1));
  assign counting  = (state_q == S_STREAM) || (state_q == S_FLUSH) || (state_q == S_DRAIN);

  always_comb begin
    cnt_full = '0;
    for (int r = 0; r < ROWS; r++) begin
      cnt_full[r] = (cnt_q[r] == CNT_W'(COLS));
    end
  end

  assign rows_full = &cnt_full;
  // A beat landing on an already complete row is the overflow case; it is dropped.
  assign ovf_beat  = counting && (|(res_valid_i & cnt_full));
  // Completion in the final DRAIN cycle takes priority over the timeout.
  assign drain_tmo = (state_q == S_DRAIN) && !rows_full &&
                     (tmr_q == TMR_W'(DRAIN_TIMEOUT - 1));

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = (cmd_k_i == '0) ? S_DONE : S_CLEAR;
      S_CLEAR:  state_d = S_STREAM;
      S_STREAM: if (rd_last) state_d = S_FLUSH;
      S_FLUSH:  if (tmr_q == TMR_W'(LANES - 1)) state_d = S_DRAIN;
      S_DRAIN:  if (rows_full || drain_tmo) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    cmd_ready_o   = (state_q == S_IDLE);
    busy_o        = (state_q != S_IDLE);
    clear_all_o   = (state_q == S_CLEAR);
    act_rd_en_o   = (state_q == S_STREAM);
    wgt_rd_en_o   = (state_q == S_STREAM);
    act_rd_addr_o = '0;
    wgt_rd_addr_o = '0;
    if (state_q == S_STREAM) begin
      // Natural ADDR_W-bit wrap gives the modulo addressing.
      act_rd_addr_o = base_q + ADDR_W'(idx_q);
      wgt_rd_addr_o = base_q + ADDR_W'(idx_q);
    end
  end

  // Command latch, read index and the FLUSH/DRAIN cycle timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_q    <= '0;
      base_q <= '0;
      idx_q  <= '0;
      tmr_q  <= '0;
    end else begin
      if (accept) begin
        k_q    <= cmd_k_i;
        base_q <= cmd_base_i;
      end
      idx_q <= (state_q == S_STREAM) ? idx_q + K_W'(1) : '0;
      if ((state_d != state_q) || !((state_q == S_FLUSH) || (state_q == S_DRAIN))) begin
        tmr_q <= '0;
      end else begin
        tmr_q <= tmr_q + TMR_W'(1);
      end
    end
  end

  // Per-row drain counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++) cnt_q[r] <= '0;
    end else if (state_q == S_CLEAR) begin
      for (int r = 0; r < ROWS; r++) cnt_q[r] <= '0;
    end else if (counting) begin
      for (int r = 0; r < ROWS; r++) begin
        if (res_valid_i[r] && !cnt_full[r]) cnt_q[r] <= cnt_q[r] + CNT_W'(1);
      end
    end
  end

  // Sticky error; the first cause to occur is the one reported.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q      <= 1'b0;
      err_code_q <= 2'd0;
    end else if (accept) begin
      err_q      <= 1'b0;
      err_code_q <= 2'd0;
    end else if (!err_q) begin
      if (ovf_beat) begin
        err_q      <= 1'b1;
        err_code_q <= 2'd2;
      end else if (drain_tmo) begin
        err_q      <= 1'b1;
        err_code_q <= 2'd1;
      end
    end
  end

  // done and stop_weight are flop outputs: done trails the DONE state by one
  // cycle, stop_weight tracks the state but reads 0 while in reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_q        <= 1'b0;
      stop_weight_q <= 1'b0;
    end else begin
      done_q        <= (state_q == S_DONE);
      stop_weight_q <= !((state_d == S_STREAM) || (state_d == S_FLUSH));
    end
  end

  assign done_o        = done_q;
  assign stop_weight_o = stop_weight_q;
  assign err_o         = err_q;
  assign err_code_o    = err_code_q;

  // Read-return qualifiers: the buffer word is valid the cycle after the strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld_q  <= 1'b0;
      rd_last_q <= 1'b0;
    end else begin
      rd_vld_q  <= (state_q == S_STREAM);
      rd_last_q <= rd_last;
    end
  end

  // Zero-fill: lanes carry 0 whenever their enable is low.
  assign act_s0 = rd_vld_q ? act_rd_data_i : '0;
  assign wgt_s0 = rd_vld_q ? wgt_rd_data_i : '0;

  // Row r gets its slice r cycles after return; row 0 is the returned word itself.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    if (r == 0) begin : g_tap0
      assign act_o[DATA_WIDTH-1:0] = act_s0[DATA_WIDTH-1:0];
      assign act_en_o[0]           = rd_vld_q;
      assign end_o[0]              = rd_last_q;
    end else begin : g_tapn
      logic [DATA_WIDTH-1:0] dat_q [r];
      logic [r-1:0]          en_q;
      logic [r-1:0]          end_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < r; i++) dat_q[i] <= '0;
          en_q  <= '0;
          end_q <= '0;
        end else begin
          dat_q[0] <= act_s0[r*DATA_WIDTH +: DATA_WIDTH];
          en_q[0]  <= rd_vld_q;
          end_q[0] <= rd_last_q;
          for (int i = 1; i < r; i++) begin
            dat_q[i] <= dat_q[i-1];
            en_q[i]  <= en_q[i-1];
            end_q[i] <= end_q[i-1];
          end
        end
      end
      assign act_o[r*DATA_WIDTH +: DATA_WIDTH] = dat_q[r-1];
      assign act_en_o[r]                       = en_q[r-1];
      assign end_o[r]                          = end_q[r-1];
    end
  end

  // Column c gets its slice c cycles after return.
  for (genvar c = 0; c < COLS; c++) begin : g_col
    if (c == 0) begin : g_tap0
      assign wgt_o[DATA_WIDTH-1:0] = wgt_s0[DATA_WIDTH-1:0];
      assign wgt_en_o[0]           = rd_vld_q;
    end else begin : g_tapn
      logic [DATA_WIDTH-1:0] dat_q [c];
      logic [c-1:0]          en_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < c; i++) dat_q[i] <= '0;
          en_q <= '0;
        end else begin
          dat_q[0] <= wgt_s0[c*DATA_WIDTH +: DATA_WIDTH];
          en_q[0]  <= rd_vld_q;
          for (int i = 1; i < c; i++) begin
            dat_q[i] <= dat_q[i-1];
            en_q[i]  <= en_q[i-1];
          end
        end
      end
      assign wgt_o[c*DATA_WIDTH +: DATA_WIDTH] = dat_q[c-1];
      assign wgt_en_o[c]                       = en_q[c-1];
    end
  end

endmodule

// File: tb/tb_systolic_tile_scheduler.sv
// Bench for systolic_tile_scheduler: random tiles against a cycle-indexed reference model.
// Cycle numbering inside a tile: rel 0 is the handshake cycle, first read strobe is rel 2.
module tb_systolic_tile_scheduler;
  localparam int DW = 16, ROWS = 4, COLS = 4, K_W = 12, ADDR_W = 12, TMO = 1024;
  localparam int LANES = 4, MAXREL = 1400;

  logic clk = 1'b0;
  logic rst;
  logic cmd_valid_i, cmd_ready_o;
  logic [K_W-1:0] cmd_k_i;
  logic [ADDR_W-1:0] cmd_base_i;
  logic act_rd_en_o, wgt_rd_en_o;
  logic [ADDR_W-1:0] act_rd_addr_o, wgt_rd_addr_o;
  logic [ROWS*DW-1:0] act_rd_data_i, act_o;
  logic [COLS*DW-1:0] wgt_rd_data_i, wgt_o;
  logic [ROWS-1:0] act_en_o, end_o, res_valid_i;
  logic [COLS-1:0] wgt_en_o;
  logic clear_all_o, stop_weight_o, busy_o, done_o, err_o;
  logic [1:0] err_code_o;

  systolic_tile_scheduler #(.DATA_WIDTH(DW), .ROWS(ROWS), .COLS(COLS), .K_W(K_W),
                            .ADDR_W(ADDR_W), .DRAIN_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_k_i(cmd_k_i), .cmd_base_i(cmd_base_i),
    .act_rd_en_o(act_rd_en_o), .act_rd_addr_o(act_rd_addr_o), .act_rd_data_i(act_rd_data_i),
    .wgt_rd_en_o(wgt_rd_en_o), .wgt_rd_addr_o(wgt_rd_addr_o), .wgt_rd_data_i(wgt_rd_data_i),
    .act_o(act_o), .act_en_o(act_en_o), .end_o(end_o), .wgt_o(wgt_o), .wgt_en_o(wgt_en_o),
    .clear_all_o(clear_all_o), .stop_weight_o(stop_weight_o), .res_valid_i(res_valid_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .err_code_o(err_code_o));

  always #5 clk = ~clk;

  // Buffer models: registered read, junk on the bus when not strobed.
  logic [63:0] act_mem [4096];
  logic [63:0] wgt_mem [4096];
  always @(posedge clk) begin
    act_rd_data_i <= act_rd_en_o ? act_mem[act_rd_addr_o] : {$urandom, $urandom};
    wgt_rd_data_i <= wgt_rd_en_o ? wgt_mem[wgt_rd_addr_o] : {$urandom, $urandom};
  end

  int errors = 0, checks = 0;
  int n_done, done_rel, last_beat, last_rel;
  int beat_left [ROWS];

  logic [63:0] r_act [MAXREL];
  logic [63:0] r_wgt [MAXREL];
  logic [3:0]  r_act_en [MAXREL], r_end [MAXREL], r_wgt_en [MAXREL];
  logic [11:0] r_addr [MAXREL], r_waddr [MAXREL];
  logic        r_rd [MAXREL], r_wrd [MAXREL], r_clear [MAXREL], r_stop [MAXREL];
  logic        r_ready [MAXREL], r_busy [MAXREL], r_err [MAXREL];
  logic [1:0]  r_code [MAXREL];

  // Present one command, record every cycle, feed result beats from beat_left.
  // lead >= 0 makes that row deliver all its beats before any other row starts.
  task automatic run_tile(input int k, input int base, input int lead);
    bit started = 1'b0;
    logic [ROWS-1:0] rv;
    n_done = 0; done_rel = -1; last_beat = -1; last_rel = MAXREL - 1;
    @(negedge clk);
    cmd_valid_i = 1'b1; cmd_k_i = K_W'(k); cmd_base_i = ADDR_W'(base);
    for (int rel = 0; rel < MAXREL; rel++) begin
      if (rel > 0) @(negedge clk);
      if (rel == 1) cmd_valid_i = 1'b0;
      r_act[rel] = act_o; r_wgt[rel] = wgt_o; r_act_en[rel] = act_en_o; r_end[rel] = end_o;
      r_wgt_en[rel] = wgt_en_o; r_addr[rel] = act_rd_addr_o; r_waddr[rel] = wgt_rd_addr_o;
      r_rd[rel] = act_rd_en_o; r_wrd[rel] = wgt_rd_en_o; r_clear[rel] = clear_all_o;
      r_stop[rel] = stop_weight_o; r_ready[rel] = cmd_ready_o; r_busy[rel] = busy_o;
      r_err[rel] = err_o; r_code[rel] = err_code_o;
      if (done_o === 1'b1) begin n_done++; if (done_rel < 0) done_rel = rel; end
      if (act_rd_en_o === 1'b1) started = 1'b1;
      rv = '0;
      if (started)
        for (int r = 0; r < ROWS; r++)
          if (beat_left[r] > 0 && (lead < 0 || r == lead || beat_left[lead] == 0) &&
              $urandom_range(0, 1) == 1) begin
            rv[r] = 1'b1; beat_left[r]--; last_beat = rel;
          end
      res_valid_i = rv;
      if (done_rel >= 0 && rel >= done_rel + 2) begin last_rel = rel; break; end
    end
    res_valid_i = '0; cmd_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid_i = 1'b0; cmd_k_i = '0; cmd_base_i = '0; res_valid_i = '0;
    repeat (3) @(negedge clk);
    checks++; if ({cmd_ready_o, busy_o, done_o, err_o, err_code_o} !== 6'b100000)
      begin errors++; $display("FAIL reset_status got=%b exp=100000", {cmd_ready_o, busy_o, done_o, err_o, err_code_o}); end
    checks++; if ({act_en_o, wgt_en_o, end_o, act_rd_en_o, wgt_rd_en_o, clear_all_o, stop_weight_o} !== 16'h0)
      begin errors++; $display("FAIL reset_outputs got=%h exp=0", {act_en_o, wgt_en_o, end_o, act_rd_en_o, wgt_rd_en_o, clear_all_o, stop_weight_o}); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (stop_weight_o !== 1'b1)
      begin errors++; $display("FAIL idle_stop_weight got=%b exp=1", stop_weight_o); end
  endtask

  // Full tile with exact per-cycle comparison of reads, lanes and status.
  task automatic test_stream(input int k, input int base);
    int d0, exp_done, kk, a;
    bit rd, b;
    logic [63:0] ea, ew;
    logic [3:0] een, eend, ewen;
    for (int r = 0; r < ROWS; r++) beat_left[r] = COLS;
    run_tile(k, base, -1);
    d0 = 2 + k + LANES;
    exp_done = ((last_beat + 1 > d0) ? last_beat + 1 : d0) + 2;
    checks++; if (r_ready[0] !== 1'b1) begin errors++; $display("FAIL stream_ready got=%b exp=1", r_ready[0]); end
    checks++; if (n_done != 1) begin errors++; $display("FAIL stream_done_count got=%0d exp=1", n_done); end
    checks++; if (done_rel != exp_done) begin errors++; $display("FAIL stream_done_cycle got=%0d exp=%0d", done_rel, exp_done); end
    if (done_rel < 0) return;
    checks++; if ({r_err[done_rel], r_code[done_rel]} !== 3'b000)
      begin errors++; $display("FAIL stream_err got=%b exp=000", {r_err[done_rel], r_code[done_rel]}); end
    for (int rel = 1; rel <= last_rel; rel++) begin
      rd = (rel >= 2 && rel < 2 + k);
      a = (base + rel - 2) % 4096;
      checks++; if ({r_rd[rel], r_wrd[rel]} !== {rd, rd})
        begin errors++; $display("FAIL rd_en rel=%0d got=%b exp=%b", rel, {r_rd[rel], r_wrd[rel]}, {rd, rd}); end
      if (rd) begin
        checks++; if ({r_addr[rel], r_waddr[rel]} !== {a[11:0], a[11:0]})
          begin errors++; $display("FAIL rd_addr rel=%0d got=%h/%h exp=%h", rel, r_addr[rel], r_waddr[rel], a[11:0]); end
      end
      checks++; if (r_clear[rel] !== (rel == 1))
        begin errors++; $display("FAIL clear rel=%0d got=%b exp=%b", rel, r_clear[rel], rel == 1); end
      checks++; if (r_stop[rel] !== !(rel >= 2 && rel < 2 + k + LANES))
        begin errors++; $display("FAIL stop_weight rel=%0d got=%b", rel, r_stop[rel]); end
      b = (rel < done_rel);
      checks++; if ({r_busy[rel], r_ready[rel]} !== {b, !b})
        begin errors++; $display("FAIL busy_ready rel=%0d got=%b exp=%b", rel, {r_busy[rel], r_ready[rel]}, {b, !b}); end
      ea = '0; een = '0; eend = '0; ew = '0; ewen = '0;
      for (int r = 0; r < ROWS; r++) begin
        kk = rel - 3 - r;
        if (kk >= 0 && kk < k) begin
          een[r] = 1'b1; eend[r] = (kk == k - 1);
          ea[r*DW +: DW] = act_mem[(base + kk) % 4096][r*DW +: DW];
        end
      end
      for (int c = 0; c < COLS; c++) begin
        kk = rel - 3 - c;
        if (kk >= 0 && kk < k) begin
          ewen[c] = 1'b1;
          ew[c*DW +: DW] = wgt_mem[(base + kk) % 4096][c*DW +: DW];
        end
      end
      checks++; if (r_act_en[rel] !== een) begin errors++; $display("FAIL act_en rel=%0d got=%b exp=%b", rel, r_act_en[rel], een); end
      checks++; if (r_end[rel] !== eend) begin errors++; $display("FAIL end rel=%0d got=%b exp=%b", rel, r_end[rel], eend); end
      checks++; if (r_act[rel] !== ea) begin errors++; $display("FAIL act_lane rel=%0d got=%h exp=%h", rel, r_act[rel], ea); end
      checks++; if (r_wgt_en[rel] !== ewen) begin errors++; $display("FAIL wgt_en rel=%0d got=%b exp=%b", rel, r_wgt_en[rel], ewen); end
      checks++; if (r_wgt[rel] !== ew) begin errors++; $display("FAIL wgt_lane rel=%0d got=%h exp=%h", rel, r_wgt[rel], ew); end
    end
  endtask

  task automatic test_k0();
    int nclr = 0, nrd = 0, nen = 0;
    for (int r = 0; r < ROWS; r++) beat_left[r] = 0;
    run_tile(0, $urandom_range(0, 4095), -1);
    for (int rel = 0; rel <= last_rel; rel++) begin
      nclr += int'(r_clear[rel]); nrd += int'(r_rd[rel] | r_wrd[rel]); nen += int'(|r_act_en[rel]);
    end
    checks++; if (n_done != 1) begin errors++; $display("FAIL k0_done_count got=%0d exp=1", n_done); end
    checks++; if (done_rel != 2) begin errors++; $display("FAIL k0_done_cycle got=%0d exp=2", done_rel); end
    checks++; if (nclr + nrd + nen != 0) begin errors++; $display("FAIL k0_activity got=%0d/%0d/%0d exp=0/0/0", nclr, nrd, nen); end
    checks++; if (r_ready[1] !== 1'b0) begin errors++; $display("FAIL k0_busy_ready got=%b exp=0", r_ready[1]); end
  endtask

  task automatic test_overflow();
    int exp_done;
    beat_left[0] = 4; beat_left[1] = 4; beat_left[2] = 5; beat_left[3] = 4;
    run_tile(8, $urandom_range(0, 4095), 2);
    exp_done = ((last_beat + 1 > 2 + 8 + LANES) ? last_beat + 1 : 2 + 8 + LANES) + 2;
    checks++; if (n_done != 1) begin errors++; $display("FAIL ovf_done_count got=%0d exp=1", n_done); end
    checks++; if (done_rel != exp_done) begin errors++; $display("FAIL ovf_done_cycle got=%0d exp=%0d", done_rel, exp_done); end
    checks++; if ({err_o, err_code_o} !== 3'b110) begin errors++; $display("FAIL ovf_err got=%b exp=110", {err_o, err_code_o}); end
  endtask

  task automatic test_timeout();
    int exp_done = 2 + 6 + LANES + TMO + 1;
    beat_left[0] = 4; beat_left[1] = 3; beat_left[2] = 4; beat_left[3] = 4;
    run_tile(6, $urandom_range(0, 4095), -1);
    checks++; if (n_done != 1) begin errors++; $display("FAIL tmo_done_count got=%0d exp=1", n_done); end
    checks++; if (done_rel != exp_done) begin errors++; $display("FAIL tmo_done_cycle got=%0d exp=%0d", done_rel, exp_done); end
    checks++; if ({err_o, err_code_o} !== 3'b101) begin errors++; $display("FAIL tmo_err got=%b exp=101", {err_o, err_code_o}); end
    // Error stays set until the next command is accepted.
    for (int r = 0; r < ROWS; r++) beat_left[r] = COLS;
    run_tile(2, $urandom_range(0, 4095), -1);
    checks++; if ({r_err[0], r_err[1]} !== 2'b10) begin errors++; $display("FAIL err_clear_on_accept got=%b exp=10", {r_err[0], r_err[1]}); end
    checks++; if (n_done != 1) begin errors++; $display("FAIL after_tmo_done got=%0d exp=1", n_done); end
  endtask

  task automatic test_reset_mid();
    int nd = 0;
    @(negedge clk);
    cmd_valid_i = 1'b1; cmd_k_i = 12'd20; cmd_base_i = ADDR_W'($urandom_range(0, 4095));
    @(negedge clk); cmd_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (act_rd_en_o !== 1'b1) begin errors++; $display("FAIL mid_in_stream got=%b exp=1", act_rd_en_o); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({act_en_o, wgt_en_o, end_o, act_rd_en_o, wgt_rd_en_o} !== 14'h0)
      begin errors++; $display("FAIL mid_enables got=%h exp=0", {act_en_o, wgt_en_o, end_o, act_rd_en_o, wgt_rd_en_o}); end
    checks++; if ({cmd_ready_o, busy_o} !== 2'b10) begin errors++; $display("FAIL mid_idle got=%b exp=10", {cmd_ready_o, busy_o}); end
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      nd += int'(done_o === 1'b1 || busy_o === 1'b1);
      @(negedge clk);
    end
    checks++; if (nd != 0) begin errors++; $display("FAIL mid_no_done got=%0d exp=0", nd); end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) begin
      act_mem[i] = {$urandom, $urandom};
      wgt_mem[i] = {$urandom, $urandom};
    end
    test_reset();
    test_stream(8, 'h010);
    test_stream(1, 'hFFF);
    test_stream(8, 'hFFE);
    for (int t = 0; t < 8; t++) test_stream($urandom_range(1, 12), $urandom_range(0, 4095));
    test_k0();
    test_overflow();
    test_timeout();
    test_reset_mid();
    test_stream(5, $urandom_range(0, 4095));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
